fetch_redirect: RTL and testbench

FETCH_REDIRECT -- requirements
Module: fetch_redirect

---
 rtl/fetch_redirect.sv | 105 ++++++++++
 tb/tb_fetch_redirect.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect.sv
// Instruction fetch front end with a single outstanding memory request.
// Branch redirects squash in-flight responses, pulse pipeline flushes and count taken branches.
module fetch_redirect #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_W,
  input  logic [N-1:0] PCBranch_W,
  input  logic         stall_F,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr_F,
  output logic [N-1:0] pc_F,
  output logic         instr_valid_F,
  output logic         flush_D,
  output logic         flush_E,
  output logic         flush_M,
  output logic [31:0]  taken_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_KILL,
    S_HOLD
  } state_t;

  localparam logic [N-1:0] ALIGN = ~N'(3);

  state_t       state;
  logic [N-1:0] pc;

  // The request is held low combinationally while reset is asserted so the
  // memory never sees a request from a block that is being cleared.
  assign imem_req  = reset && (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_REQ;
      pc            <= RESET_PC & ALIGN;
      instr_F       <= '0;
      pc_F          <= '0;
      instr_valid_F <= 1'b0;
      flush_D       <= 1'b0;
      flush_E       <= 1'b0;
      flush_M       <= 1'b0;
      taken_count   <= '0;
    end else begin
      flush_D <= PCSrc_W;
      flush_E <= PCSrc_W;
      flush_M <= PCSrc_W;
      if (PCSrc_W && (taken_count != 32'hFFFF_FFFF))
        taken_count <= taken_count + 32'd1;

      if (PCSrc_W) begin
        pc            <= PCBranch_W & ALIGN;
        instr_valid_F <= 1'b0;
        // A granted-but-unanswered request must have its response swallowed.
        case (state)
          S_REQ:          state <= imem_gnt ? S_KILL : S_REQ;
          S_WAIT, S_KILL: state <= imem_rvalid ? S_REQ : S_KILL;
          default:        state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_REQ: begin
            instr_valid_F <= 1'b0;
            if (imem_gnt)
              state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              instr_F       <= imem_rdata;
              pc_F          <= pc;
              instr_valid_F <= 1'b1;
              pc            <= pc + N'(4);
              state         <= stall_F ? S_HOLD : S_REQ;
            end else begin
              instr_valid_F <= 1'b0;
            end
          end
          S_KILL: begin
            instr_valid_F <= 1'b0;
            if (imem_rvalid)
              state <= S_REQ;
          end
          S_HOLD: begin
            if (!stall_F) begin
              instr_valid_F <= 1'b0;
              state         <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: sequential fetch, stall, redirects,
// stale-response dropping, counter saturation and asynchronous reset.
module tb_fetch_redirect;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         PCSrc_W;
  logic [N-1:0] PCBranch_W;
  logic         stall_F;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  instr_F;
  logic [N-1:0] pc_F;
  logic         instr_valid_F;
  logic         flush_D;
  logic         flush_E;
  logic         flush_M;
  logic [31:0]  taken_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect #(.N(N), .RESET_PC('0)) dut (
    .clk(clk),
    .reset(reset),
    .PCSrc_W(PCSrc_W),
    .PCBranch_W(PCBranch_W),
    .stall_F(stall_F),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_F(instr_F),
    .pc_F(pc_F),
    .instr_valid_F(instr_valid_F),
    .flush_D(flush_D),
    .flush_E(flush_E),
    .flush_M(flush_M),
    .taken_count(taken_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    PCSrc_W     = 1'b0;
    PCBranch_W  = '0;
    stall_F     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset state
    #3 reset = 1'b0;
    #1;
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid_F), 64'd0);
    chk("rst_count", 64'(taken_count), 64'd0);
    chk("rst_pcf",   pc_F, 64'd0);
    chk("rst_flush", 64'(flush_D), 64'd0);
    tick();
    tick();
    @(negedge clk);
    reset    = 1'b1;
    imem_gnt = 1'b1;
    #1;
    chk("req0",  64'(imem_req), 64'd1);
    chk("addr0", imem_addr, 64'h0);

    // Sequential fetch
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    chk("wait_req", 64'(imem_req), 64'd0);
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    chk("f0_valid", 64'(instr_valid_F), 64'd1);
    chk("f0_pc",    pc_F, 64'h0);
    chk("f0_instr", 64'(instr_F), 64'h13);
    chk("req4",     64'(imem_req), 64'd1);
    chk("addr4",    imem_addr, 64'h4);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; stall_F = 1'b1;
    chk("f0_drop_valid", 64'(instr_valid_F), 64'd0);

    // Stall held for three cycles at pc_F=0x4
    tick();
    imem_rvalid = 1'b0;
    chk("h1_valid", 64'(instr_valid_F), 64'd1);
    chk("h1_pc",    pc_F, 64'h4);
    chk("h1_req",   64'(imem_req), 64'd0);
    tick();
    chk("h2_valid", 64'(instr_valid_F), 64'd1);
    chk("h2_pc",    pc_F, 64'h4);
    chk("h2_req",   64'(imem_req), 64'd0);
    tick();
    stall_F = 1'b0;
    chk("h3_valid", 64'(instr_valid_F), 64'd1);
    chk("h3_instr", 64'(instr_F), 64'h0050_0093);
    tick();
    chk("req8",        64'(imem_req), 64'd1);
    chk("addr8",       imem_addr, 64'h8);
    chk("post_hold_v", 64'(instr_valid_F), 64'd0);

    // Redirect in WAIT, stale response dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; PCSrc_W = 1'b1; PCBranch_W = 64'h100;
    tick();
    PCSrc_W = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    chk("rw_flushD", 64'(flush_D), 64'd1);
    chk("rw_flushE", 64'(flush_E), 64'd1);
    chk("rw_flushM", 64'(flush_M), 64'd1);
    chk("rw_req",    64'(imem_req), 64'd0);
    chk("rw_count",  64'(taken_count), 64'd1);
    tick();
    imem_rvalid = 1'b0;
    chk("rw_flush_off", 64'(flush_D), 64'd0);
    chk("rw_drop_v",    64'(instr_valid_F), 64'd0);
    chk("rw_drop_i",    64'(instr_F), 64'h0050_0093);
    chk("rw_req2",      64'(imem_req), 64'd1);
    chk("rw_addr",      imem_addr, 64'h100);

    // Redirect beats same-cycle rvalid and stall
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; stall_F = 1'b1; PCSrc_W = 1'b1;
    PCBranch_W = 64'h180; imem_rdata = 32'h1234_5678;
    tick();
    imem_rvalid = 1'b0; stall_F = 1'b0; PCSrc_W = 1'b0;
    chk("pr_valid", 64'(instr_valid_F), 64'd0);
    chk("pr_req",   64'(imem_req), 64'd1);
    chk("pr_addr",  imem_addr, 64'h180);
    chk("pr_pcf",   pc_F, 64'h4);
    chk("pr_count", 64'(taken_count), 64'd2);

    // Back-to-back redirects (second one during KILL, unaligned target)
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; PCSrc_W = 1'b1; PCBranch_W = 64'h200;
    tick();
    PCBranch_W = 64'h303;
    chk("bb1_flush", 64'(flush_D), 64'd1);
    tick();
    PCSrc_W = 1'b0; imem_rvalid = 1'b1;
    chk("bb2_flush", 64'(flush_M), 64'd1);
    chk("bb2_req",   64'(imem_req), 64'd0);
    chk("bb2_count", 64'(taken_count), 64'd4);
    tick();
    imem_rvalid = 1'b0;
    chk("bb_flush_off", 64'(flush_E), 64'd0);
    chk("bb_req",       64'(imem_req), 64'd1);
    chk("bb_addr",      imem_addr, 64'h300);

    // Redirect with same-cycle grant in REQ: grant is stale
    imem_gnt = 1'b1; PCSrc_W = 1'b1; PCBranch_W = 64'h400;
    tick();
    imem_gnt = 1'b0; PCSrc_W = 1'b0;
    chk("rg_req",   64'(imem_req), 64'd0);
    chk("rg_flush", 64'(flush_E), 64'd1);
    chk("rg_count", 64'(taken_count), 64'd5);
    tick();
    imem_rvalid = 1'b1;
    chk("rg_kill_req", 64'(imem_req), 64'd0);
    tick();
    imem_rvalid = 1'b0;
    chk("rg_req2",  64'(imem_req), 64'd1);
    chk("rg_addr",  imem_addr, 64'h400);
    chk("rg_valid", 64'(instr_valid_F), 64'd0);
    tick();
    chk("nogrant_req",  64'(imem_req), 64'd1);
    chk("nogrant_addr", imem_addr, 64'h400);

    // Counter saturation
    force dut.taken_count = 32'hFFFF_FFFE;
    #1;
    release dut.taken_count;
    PCSrc_W = 1'b1; PCBranch_W = 64'h500;
    tick();
    chk("sat1", 64'(taken_count), 64'hFFFF_FFFF);
    tick();
    tick();
    PCSrc_W = 1'b0;
    chk("sat3", 64'(taken_count), 64'hFFFF_FFFF);
    chk("sat_addr", imem_addr, 64'h500);

    // Fetch at 0x500, then reset asynchronously mid-WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    chk("f5_pc",    pc_F, 64'h500);
    chk("f5_instr", 64'(instr_F), 64'h00A0_0113);
    tick();
    imem_gnt = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("ar_instr", 64'(instr_F), 64'h0);
    chk("ar_pcf",   pc_F, 64'h0);
    chk("ar_valid", 64'(instr_valid_F), 64'd0);
    chk("ar_count", 64'(taken_count), 64'd0);
    chk("ar_req",   64'(imem_req), 64'd0);
    chk("ar_flush", 64'(flush_D), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_req",  64'(imem_req), 64'd1);
    chk("rel_addr", imem_addr, 64'h0);
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", 64'(instr_valid_F), 64'd0);
    chk("stale_instr", 64'(instr_F), 64'h0);
    chk("stale_req",   64'(imem_req), 64'd1);
    chk("stale_addr",  imem_addr, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
